// File: rtl/tm1637_pkg.sv
// ---------------------------------------------------------------------------
// tm1637_pkg
// Shared types and command bytes for the TM1637 display driver.
//   state_t      : serial-engine state encoding
//   frame_idx_t  : which frame of a refresh is being sent
//   CMD_*        : fixed TM1637 command bytes
//   disp_ctrl_byte() : builds the display-control command from on/brightness
// Optional feature macro: TM1637_KEYSCAN_EN (used by tm1637_driver).
// ---------------------------------------------------------------------------
package tm1637_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_NEXT
    } state_t;

    typedef enum logic [1:0] {
        FRAME_DATA,
        FRAME_ADDR,
        FRAME_DISP,
        FRAME_KEY
    } frame_idx_t;

    localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
    localparam logic [7:0] CMD_ADDR0     = 8'hC0;
    localparam logic [7:0] CMD_DISP_BASE = 8'h80;
    localparam logic [7:0] CMD_KEY_READ  = 8'h42;

    // Display-control byte: bit 3 switches the display on, bits 2:0 set PWM level.
    function automatic logic [7:0] disp_ctrl_byte(input logic display_on,
                                                  input logic [2:0] brightness);
        return CMD_DISP_BASE | {4'b0000, display_on, brightness};
    endfunction

endpackage

// File: rtl/tm1637_driver_tick.sv
// ---------------------------------------------------------------------------
// tm1637_tick
// Half-bit-period time base for the TM1637 serial engine.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   clear        : restart the period (used when a refresh is accepted)
//   tick         : one-cycle pulse every HALF_PERIOD cycles
// ---------------------------------------------------------------------------
module tm1637_tick #(
    parameter int HALF_PERIOD = 250
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Tick fires on the last count of each period so the first tick after a
    // clear lands exactly HALF_PERIOD cycles later.
    always_comb begin
        tick    = (count_q == CW'(HALF_PERIOD - 1));
        count_d = count_q + 1'b1;
        if (clear || tick) begin
            count_d = '0;
        end
    end

    // Counter register, restarted by the synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tm1637_driver.sv
// ---------------------------------------------------------------------------
// tm1637_driver
// Serial master for a TM1637 LED controller. A start pulse sends one full
// refresh: data command, address + digit bytes, display control.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   start         : refresh request, accepted only when idle
//   seg_data      : digit segment bytes, digit0 in [7:0] is sent first
//   brightness    : PWM level 0..7
//   display_on    : display enable bit of the control byte
//   busy, done    : transaction in progress / one-cycle end pulse
//   ack_err       : sticky, an ACK was sampled high during this refresh
//   key_code      : last key-scan byte (8'hFF when key scan is not built)
//   tm_clk        : TM1637 CLK, push-pull, idle high
//   tm_dio_oe     : 1 pulls DIO low, 0 releases it to the pull-up
//   tm_dio_in     : synchronised DIO readback
// Optional feature macro: TM1637_KEYSCAN_EN appends a key-read frame.
// ---------------------------------------------------------------------------
module tm1637_driver
    import tm1637_pkg::*;
#(
    parameter int HALF_PERIOD = 250,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*NUM_DIGITS-1:0] seg_data,
    input  logic [2:0]              brightness,
    input  logic                    display_on,
    output logic                    busy,
    output logic                    done,
    output logic                    ack_err,
    output logic [7:0]              key_code,
    output logic                    tm_clk,
    output logic                    tm_dio_oe,
    input  logic                    tm_dio_in
);

`ifdef TM1637_KEYSCAN_EN
    localparam frame_idx_t LAST_FRAME = FRAME_KEY;
`else
    localparam frame_idx_t LAST_FRAME = FRAME_DISP;
`endif

    state_t                  state_q,  state_d;
    frame_idx_t              frame_q,  frame_d;
    logic [1:0]              phase_q,  phase_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [2:0]              byte_idx_q, byte_idx_d;
    logic                    frame_end_q, frame_end_d;
    logic                    clk_q,    clk_d;
    logic                    oe_q,     oe_d;
    logic                    ack_err_q, ack_err_d;
    logic [8*NUM_DIGITS-1:0] seg_q,    seg_d;
    logic [2:0]              bright_q, bright_d;
    logic                    on_q,     on_d;
`ifdef TM1637_KEYSCAN_EN
    logic [7:0]              rx_q,     rx_d;
    logic [7:0]              key_code_q, key_code_d;
`endif

    logic       tick;
    logic       accept;
    logic       last_byte;
    logic       reading;
    logic [7:0] cur_byte;

    assign accept = (state_q == ST_IDLE) && start;

    tm1637_tick #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .clear(accept),
        .tick (tick)
    );

    // Byte currently on the wire, chosen from the frame and byte position.
    // Byte 0 of every frame is its command; address-frame bytes 1..N are digits.
    always_comb begin
        cur_byte = 8'h00;
        case (frame_q)
            FRAME_DATA: cur_byte = CMD_DATA_AUTO;
            FRAME_ADDR: begin
                cur_byte = CMD_ADDR0;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (byte_idx_q == 3'(i + 1)) begin
                        cur_byte = seg_q[i*8 +: 8];
                    end
                end
            end
            FRAME_DISP: cur_byte = disp_ctrl_byte(on_q, bright_q);
            default:    cur_byte = CMD_KEY_READ;
        endcase
    end

    // Frame length bookkeeping, and whether the current byte is read from the
    // slave rather than driven (only the second byte of the key frame).
    always_comb begin
        case (frame_q)
            FRAME_ADDR: last_byte = (byte_idx_q == 3'(NUM_DIGITS));
            FRAME_KEY:  last_byte = (byte_idx_q == 3'd1);
            default:    last_byte = (byte_idx_q == 3'd0);
        endcase
`ifdef TM1637_KEYSCAN_EN
        reading = (frame_q == FRAME_KEY) && (byte_idx_q == 3'd1);
`else
        reading = 1'b0;
`endif
    end

    // Next-state logic. Every line change waits for a tick; phase_q walks the
    // half-periods inside START (0..1), BIT/ACK (0..2) and STOP (0..3).
    // The last high-half cycle of a bit is the tick cycle that drops the clock,
    // which is where DIO is sampled for ACKs and key bits.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        frame_end_d = frame_end_q;
        clk_d       = clk_q;
        oe_d        = oe_q;
        ack_err_d   = ack_err_q;
        seg_d       = seg_q;
        bright_d    = bright_q;
        on_d        = on_q;
`ifdef TM1637_KEYSCAN_EN
        rx_d        = rx_q;
        key_code_d  = key_code_q;
`endif

        case (state_q)
            ST_IDLE: begin
                clk_d = 1'b1;
                oe_d  = 1'b0;
                if (start) begin
                    seg_d       = seg_data;
                    bright_d    = brightness;
                    on_d        = display_on;
                    ack_err_d   = 1'b0;
                    frame_d     = FRAME_DATA;
                    byte_idx_d  = 3'd0;
                    bit_cnt_d   = 3'd0;
                    phase_d     = 2'd0;
                    frame_end_d = 1'b0;
                    state_d     = ST_START;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (phase_q == 2'd0) begin
                        oe_d    = 1'b1;
                        phase_d = 2'd1;
                    end else begin
                        clk_d      = 1'b0;
                        phase_d    = 2'd0;
                        bit_cnt_d  = 3'd0;
                        byte_idx_d = 3'd0;
                        state_d    = ST_BIT;
                    end
                end
            end

            ST_BIT: begin
                if (tick) begin
                    case (phase_q)
                        2'd0: begin
                            oe_d    = reading ? 1'b0 : ~cur_byte[bit_cnt_q];
                            phase_d = 2'd1;
                        end
                        2'd1: begin
                            clk_d   = 1'b1;
                            phase_d = 2'd2;
                        end
                        default: begin
`ifdef TM1637_KEYSCAN_EN
                            if (reading) begin
                                rx_d[bit_cnt_q] = tm_dio_in;
                            end
`endif
                            clk_d   = 1'b0;
                            phase_d = 2'd0;
                            if (bit_cnt_q == 3'd7) begin
                                bit_cnt_d = 3'd0;
                                state_d   = ST_ACK;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                            end
                        end
                    endcase
                end
            end

            ST_ACK: begin
                if (tick) begin
                    case (phase_q)
                        2'd0: begin
                            oe_d    = 1'b0;
                            phase_d = 2'd1;
                        end
                        2'd1: begin
                            clk_d   = 1'b1;
                            phase_d = 2'd2;
                        end
                        default: begin
                            if (!reading && tm_dio_in) begin
                                ack_err_d = 1'b1;
                            end
                            clk_d   = 1'b0;
                            phase_d = 2'd0;
                            if (last_byte) begin
                                state_d = ST_STOP;
                            end else begin
                                frame_end_d = 1'b0;
                                state_d     = ST_NEXT;
                            end
                        end
                    endcase
                end
            end

            ST_STOP: begin
                if (tick) begin
                    case (phase_q)
                        2'd0: begin
                            oe_d    = 1'b1;
                            phase_d = 2'd1;
                        end
                        2'd1: begin
                            clk_d   = 1'b1;
                            phase_d = 2'd2;
                        end
                        2'd2: begin
                            oe_d    = 1'b0;
                            phase_d = 2'd3;
                        end
                        default: begin
`ifdef TM1637_KEYSCAN_EN
                            if (frame_q == FRAME_KEY) begin
                                key_code_d = rx_q;
                            end
`endif
                            phase_d     = 2'd0;
                            frame_end_d = 1'b1;
                            state_d     = ST_NEXT;
                        end
                    endcase
                end
            end

            ST_NEXT: begin
                phase_d   = 2'd0;
                bit_cnt_d = 3'd0;
                if (!frame_end_q) begin
                    byte_idx_d = byte_idx_q + 3'd1;
                    state_d    = ST_BIT;
                end else if (frame_q == LAST_FRAME) begin
                    state_d = ST_IDLE;
                end else begin
                    case (frame_q)
                        FRAME_DATA: frame_d = FRAME_ADDR;
                        FRAME_ADDR: frame_d = FRAME_DISP;
                        default:    frame_d = FRAME_KEY;
                    endcase
                    state_d = ST_START;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State register. Reset releases both lines immediately without a STOP.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            frame_q     <= FRAME_DATA;
            phase_q     <= 2'd0;
            bit_cnt_q   <= 3'd0;
            byte_idx_q  <= 3'd0;
            frame_end_q <= 1'b0;
            clk_q       <= 1'b1;
            oe_q        <= 1'b0;
            ack_err_q   <= 1'b0;
            seg_q       <= '0;
            bright_q    <= 3'd0;
            on_q        <= 1'b0;
`ifdef TM1637_KEYSCAN_EN
            rx_q        <= 8'hFF;
            key_code_q  <= 8'hFF;
`endif
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_idx_q  <= byte_idx_d;
            frame_end_q <= frame_end_d;
            clk_q       <= clk_d;
            oe_q        <= oe_d;
            ack_err_q   <= ack_err_d;
            seg_q       <= seg_d;
            bright_q    <= bright_d;
            on_q        <= on_d;
`ifdef TM1637_KEYSCAN_EN
            rx_q        <= rx_d;
            key_code_q  <= key_code_d;
`endif
        end
    end

    // Status outputs. The NEXT cycle after the final STOP is the done cycle,
    // and busy drops in that same cycle.
    always_comb begin
        done = (state_q == ST_NEXT) && frame_end_q && (frame_q == LAST_FRAME);
        busy = (state_q != ST_IDLE) && !done;
    end

    assign tm_clk    = clk_q;
    assign tm_dio_oe = oe_q;
    assign ack_err   = ack_err_q;
`ifdef TM1637_KEYSCAN_EN
    assign key_code  = key_code_q;
`else
    assign key_code  = 8'hFF;
`endif

endmodule

// File: tb/tb_tm1637_driver.sv
// ---------------------------------------------------------------------------
// tb_tm1637_driver
// Directed bench for tm1637_driver with an open-drain DIO line and a TM1637
// slave model that decodes START/bytes/STOP, ACKs bytes and answers key reads.
// Honours TM1637_KEYSCAN_EN for the expected frame list and key_code.
// ---------------------------------------------------------------------------
module tb_tm1637_driver;

    localparam int HALF_PERIOD = 4;
    localparam int NUM_DIGITS  = 4;
    localparam int S = 32'h100;
    localparam int P = 32'h200;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] seg_data;
    logic [2:0]  brightness;
    logic        display_on;
    logic        busy;
    logic        done;
    logic        ack_err;
    logic [7:0]  key_code;
    logic        tm_clk;
    logic        tm_dio_oe;
    logic        dio_line;

    int checks = 0;
    int errors = 0;

    logic       slave_pull = 1'b0;
    logic [8:0] nack_byte  = 9'h100;
    logic [7:0] key_val    = 8'hEF;
    logic       p_clk      = 1'b1;
    logic       p_dio      = 1'b1;
    logic [7:0] sh         = 8'h00;
    logic       reading    = 1'b0;
    int         model_bit  = 0;
    int         frame_cnt  = 0;
    int         done_cnt   = 0;
    int         log_q[$];
    int         exp_q[$];

    always #5 clock = ~clock;

    assign dio_line = ~(tm_dio_oe | slave_pull);

    tm1637_driver #(
        .HALF_PERIOD(HALF_PERIOD),
        .NUM_DIGITS (NUM_DIGITS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .seg_data  (seg_data),
        .brightness(brightness),
        .display_on(display_on),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .key_code  (key_code),
        .tm_clk    (tm_clk),
        .tm_dio_oe (tm_dio_oe),
        .tm_dio_in (dio_line)
    );

    // Slave model: decodes the bus on the falling system edge, logs START (S),
    // STOP (P) and every byte seen on the line, ACKs written bytes unless told
    // to withhold, and drives key_val LSB-first after a 0x42 command.
    always @(negedge clock) begin
        if (p_clk && tm_clk && p_dio && !dio_line) begin
            log_q.push_back(S);
            model_bit  = 0;
            reading    = 1'b0;
            slave_pull = 1'b0;
            frame_cnt++;
        end else if (p_clk && tm_clk && !p_dio && dio_line) begin
            log_q.push_back(P);
        end else if (!p_clk && tm_clk) begin
            if (model_bit < 8) sh[model_bit] = dio_line;
            model_bit++;
        end else if (p_clk && !tm_clk) begin
            if (model_bit == 8) begin
                log_q.push_back(int'(sh));
                slave_pull = reading ? 1'b0 : ({1'b0, sh} != nack_byte);
            end else if (model_bit == 9) begin
                model_bit  = 0;
                slave_pull = 1'b0;
                if (reading) begin
                    reading = 1'b0;
                end else if (sh == 8'h42) begin
                    reading    = 1'b1;
                    slave_pull = ~key_val[0];
                end
            end else if (reading && model_bit >= 1 && model_bit < 8) begin
                slave_pull = ~key_val[model_bit];
            end
        end
        p_clk = tm_clk;
        p_dio = dio_line;
    end

    // Done pulse counter.
    always @(negedge clock) begin
        if (done) done_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] seg, input logic [2:0] bri,
                                 input logic on);
        @(negedge clock);
        seg_data   = seg;
        brightness = bri;
        display_on = on;
        start      = 1'b1;
        @(negedge clock);
        start      = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        for (int i = 0; i < 6000; i++) begin
            if (done) break;
            @(negedge clock);
        end
        checkOutput(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic compareLog(input string tag, input int base);
        checkOutput({tag, "_len"}, 32'(log_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < log_q.size())
                checkOutput($sformatf("%s_%0d", tag, i), 32'(log_q[base+i]), 32'(exp_q[i]));
            else
                checkOutput($sformatf("%s_%0d", tag, i), 32'hDEAD, 32'(exp_q[i]));
        end
    endtask

    initial begin
        int base;
        int dbase;
        int fbase;
        int act;
        logic [7:0] exp_key;
        logic found;

`ifdef TM1637_KEYSCAN_EN
        exp_key = 8'hEF;
`else
        exp_key = 8'hFF;
`endif
        reset      = 1'b1;
        start      = 1'b0;
        seg_data   = 32'h0;
        brightness = 3'd0;
        display_on = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_busy",   {31'd0, busy},      32'd0);
        checkOutput("rst_done",   {31'd0, done},      32'd0);
        checkOutput("rst_ackerr", {31'd0, ack_err},   32'd0);
        checkOutput("rst_key",    {24'd0, key_code},  32'hFF);
        checkOutput("rst_clk",    {31'd0, tm_clk},    32'd1);
        checkOutput("rst_oe",     {31'd0, tm_dio_oe}, 32'd0);
        reset = 1'b0;

        $display("[TB] idle after reset");
        act = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (tm_clk !== 1'b1 || tm_dio_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) act++;
        end
        checkOutput("idle_activity", 32'(act), 32'd0);

        $display("[TB] normal refresh");
        exp_q = '{S, 32'h40, P, S, 32'hC0, 32'h4F, 32'h5B, 32'h06, 32'h3F, P, S, 32'h8F, P};
`ifdef TM1637_KEYSCAN_EN
        exp_q.push_back(S); exp_q.push_back(32'h42); exp_q.push_back(32'hEF); exp_q.push_back(P);
`endif
        base  = log_q.size();
        dbase = done_cnt;
        applyStimulus(32'h3F065B4F, 3'd7, 1'b1);
        checkOutput("accept_busy", {31'd0, busy}, 32'd1);
        waitDone("t2_done");
        checkOutput("t2_busy_at_done", {31'd0, busy}, 32'd0);
        checkOutput("t2_key_at_done", {24'd0, key_code}, {24'd0, exp_key});
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput("start_at_done_ignored", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clock);
        checkOutput("t2_done_pulses", 32'(done_cnt - dbase), 32'd1);
        checkOutput("t2_ackerr", {31'd0, ack_err}, 32'd0);
        compareLog("t2_log", base);

        $display("[TB] withheld ACK");
        nack_byte = 9'h04F;
        base = log_q.size();
        applyStimulus(32'h3F065B4F, 3'd7, 1'b1);
        waitDone("t3_done");
        nack_byte = 9'h100;
        repeat (5) @(negedge clock);
        checkOutput("t3_ackerr_set", {31'd0, ack_err}, 32'd1);
        compareLog("t3_log", base);
        applyStimulus(32'h3F065B4F, 3'd7, 1'b1);
        checkOutput("t3_ackerr_cleared", {31'd0, ack_err}, 32'd0);
        waitDone("t3_done2");
        checkOutput("t3_ackerr_final", {31'd0, ack_err}, 32'd0);
        repeat (5) @(negedge clock);

        $display("[TB] restart request and input change mid-refresh");
        base  = log_q.size();
        dbase = done_cnt;
        applyStimulus(32'h3F065B4F, 3'd7, 1'b1);
        repeat (300) @(negedge clock);
        seg_data = 32'hFFFFFFFF;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        checkOutput("t4_still_busy", {31'd0, busy}, 32'd1);
        waitDone("t4_done");
        repeat (10) @(negedge clock);
        checkOutput("t4_done_pulses", 32'(done_cnt - dbase), 32'd1);
        compareLog("t4_log", base);

        $display("[TB] reset mid-transaction");
        fbase = frame_cnt;
        applyStimulus(32'h3F065B4F, 3'd7, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (frame_cnt - fbase == 2 && model_bit == 3) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checkOutput("t5_reached_bit3", {31'd0, found}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("t5_busy",  {31'd0, busy},      32'd0);
        checkOutput("t5_clk",   {31'd0, tm_clk},    32'd1);
        checkOutput("t5_oe",    {31'd0, tm_dio_oe}, 32'd0);
        checkOutput("t5_key",   {24'd0, key_code},  32'hFF);
        repeat (20) @(negedge clock);
        exp_q = '{S, 32'h40, P, S, 32'hC0, 32'h04, 32'h03, 32'h02, 32'h01, P, S, 32'h82, P};
`ifdef TM1637_KEYSCAN_EN
        exp_q.push_back(S); exp_q.push_back(32'h42); exp_q.push_back(32'hEF); exp_q.push_back(P);
`endif
        base = log_q.size();
        applyStimulus(32'h01020304, 3'd2, 1'b0);
        waitDone("t5_done");
        checkOutput("t5_key_at_done", {24'd0, key_code}, {24'd0, exp_key});
        repeat (10) @(negedge clock);
        compareLog("t5_log", base);
        checkOutput("t5_ackerr", {31'd0, ack_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
